// File: rtl/instr_fetch_unit.sv
`timescale 1ns/1ps
// instr_fetch_unit
//   Upstream stage of the multi-cycle CPU controller. Owns the PC, fetches
//   opcode/operand bytes over an 8-bit single-outstanding memory port,
//   classifies each opcode as one- or two-byte, and presents IR/TR/flags
//   to the controller via a valid/ready handshake. Accepts PC redirects,
//   including redirects that arrive while a fetch is in flight.
//
// Ports
//   clk, rst      clock; asynchronous active-high reset
//   en            fetch enable (low: finish current instruction, then idle)
//   mem_req       read request, held until mem_ack
//   mem_addr      read byte address, stable while mem_req is high
//   mem_ack       read data valid; transfer completes at this edge
//   mem_rdata     read data byte
//   ir_out        opcode byte
//   tr_out        operand byte (held for one-byte instructions)
//   two_byte      opcode decodes as a two-byte instruction
//   instr_addr    address of the opcode byte of the presented instruction
//   pc_out        registered PC (next byte to fetch)
//   instr_valid   instruction presented to controller
//   instr_ready   controller consumes the instruction
//   pc_load       redirect request
//   pc_target     redirect address
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W   = 13,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        ir_out,
  output logic [7:0]        tr_out,
  output logic              two_byte,
  output logic [ADDR_W-1:0] instr_addr,
  output logic [ADDR_W-1:0] pc_out,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_target
);

  typedef enum logic [1:0] {IDLE, FETCH1, FETCH2, VALID} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc, pc_next;
  logic [ADDR_W-1:0] iaddr, iaddr_next;
  logic [ADDR_W-1:0] redir_target, redir_target_next;
  logic              redir_pending, redir_pending_next;
  logic [7:0]        ir, ir_next;
  logic [7:0]        tr, tr_next;
  logic              two, two_next;
  logic              fetching;

  function automatic logic is_two_byte(input logic [7:0] op);
    return (op[7] == 1'b0) || (op[7:5] == 3'b110);
  endfunction

  assign fetching    = (state == FETCH1) || (state == FETCH2);
  assign mem_req     = fetching;
  assign mem_addr    = fetching ? pc : '0;
  assign instr_valid = (state == VALID);
  assign ir_out      = ir;
  assign tr_out      = tr;
  assign two_byte    = two;
  assign instr_addr  = iaddr;
  assign pc_out      = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The two-byte flag is registered with IR rather than decoded from it so
  // that it reads 0 out of reset (IR=0 would otherwise decode as two-byte).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc            <= RESET_PC;
      iaddr         <= '0;
      redir_target  <= '0;
      redir_pending <= 1'b0;
      ir            <= '0;
      tr            <= '0;
      two           <= 1'b0;
    end else begin
      pc            <= pc_next;
      iaddr         <= iaddr_next;
      redir_target  <= redir_target_next;
      redir_pending <= redir_pending_next;
      ir            <= ir_next;
      tr            <= tr_next;
      two           <= two_next;
    end
  end

  always_comb begin
    state_next         = state;
    pc_next            = pc;
    iaddr_next         = iaddr;
    redir_target_next  = redir_target;
    redir_pending_next = redir_pending;
    ir_next            = ir;
    tr_next            = tr;
    two_next           = two;

    case (state)
      IDLE: begin
        if (pc_load) pc_next = pc_target;
        if (en) state_next = FETCH1;
      end

      FETCH1, FETCH2: begin
        if (mem_ack) begin
          if (redir_pending || pc_load) begin
            // A redirect raced the in-flight read: drop the byte and
            // restart from the newest target.
            pc_next            = pc_load ? pc_target : redir_target;
            redir_pending_next = 1'b0;
            state_next         = en ? FETCH1 : IDLE;
          end else if (state == FETCH1) begin
            ir_next    = mem_rdata;
            two_next   = is_two_byte(mem_rdata);
            iaddr_next = pc;
            pc_next    = pc + 1'b1;
            state_next = is_two_byte(mem_rdata) ? FETCH2 : VALID;
          end else begin
            tr_next    = mem_rdata;
            pc_next    = pc + 1'b1;
            state_next = VALID;
          end
        end else if (pc_load) begin
          // Request must stay stable until ack; remember the target instead.
          redir_target_next  = pc_target;
          redir_pending_next = 1'b1;
        end
      end

      VALID: begin
        if (pc_load) begin
          pc_next    = pc_target;
          state_next = en ? FETCH1 : IDLE;
        end else if (instr_ready) begin
          state_next = en ? FETCH1 : IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  localparam int unsigned AW = 13;

  typedef struct packed {
    logic [7:0]    ir;
    logic [7:0]    tr;
    logic          two;
    logic [AW-1:0] addr;
    logic [AW-1:0] pc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack = 1'b0;
  logic [7:0]    mem_rdata = '0;
  logic [7:0]    ir_out;
  logic [7:0]    tr_out;
  logic          two_byte;
  logic [AW-1:0] instr_addr;
  logic [AW-1:0] pc_out;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic          pc_load = 1'b0;
  logic [AW-1:0] pc_target = '0;

  int checks = 0;
  int errors = 0;

  logic [7:0]    mem [0:(1<<AW)-1];
  exp_t          exp_q [$];
  logic [AW-1:0] fetch_log [$];
  bit            auto_mem = 1'b1;
  int            wait_cyc = 0;
  int            wcnt = 0;
  bit            req_active = 1'b0;
  logic [AW-1:0] req_addr = '0;

  exp_t got, e;
  bit   ok;

  instr_fetch_unit #(.ADDR_W(AW), .RESET_PC(13'h0000)) dut (
    .clk(clk), .rst(rst), .en(en),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ir_out(ir_out), .tr_out(tr_out), .two_byte(two_byte), .instr_addr(instr_addr),
    .pc_out(pc_out), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc_load(pc_load), .pc_target(pc_target)
  );

  always #5 clk = ~clk;

  // Memory responder: acks after wait_cyc wait cycles, logs accepted
  // addresses and checks mem_addr stays put while the request is open.
  initial begin
    forever begin
      @(negedge clk);
      if (auto_mem) begin
        mem_ack = 1'b0;
        if (mem_req) begin
          if (!req_active) begin
            req_active = 1'b1;
            wcnt       = 0;
            req_addr   = mem_addr;
          end else begin
            checks++;
            if (mem_addr !== req_addr) begin
              errors++;
              $display("FAIL addr_stable: mem_addr=%h expected %h", mem_addr, req_addr);
            end
          end
          if (wcnt >= wait_cyc) begin
            mem_ack    = 1'b1;
            mem_rdata  = mem[mem_addr];
            req_active = 1'b0;
            fetch_log.push_back(mem_addr);
          end else begin
            wcnt++;
          end
        end else begin
          req_active = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_valid(output bit found);
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (instr_valid) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_req, instr_valid, mem_addr} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: req=%b valid=%b addr=%h expected 0/0/0", mem_req, instr_valid, mem_addr);
    end
    got = {ir_out, tr_out, two_byte, instr_addr, pc_out};
    checks++;
    if (got !== exp_t'(0)) begin
      errors++;
      $display("FAIL reset_regs: got %h expected %h", got, exp_t'(0));
    end
    rst = 1'b0;
  endtask

  task automatic test_one_byte();
    mem[0] = 8'hA3;
    wait_cyc = 0;
    @(negedge clk);
    en = 1'b1;
    exp_q.push_back('{ir: 8'hA3, tr: 8'h00, two: 1'b0, addr: 13'h0000, pc: 13'h0001});
    @(negedge clk);
    checks++;
    if (!(mem_req === 1'b1 && mem_addr === 13'h0000 && instr_valid === 1'b0)) begin
      errors++;
      $display("FAIL one_byte_req: req=%b addr=%h valid=%b expected 1/0000/0", mem_req, mem_addr, instr_valid);
    end
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL one_byte_latency: instr_valid=%b expected 1", instr_valid);
    end else begin
      e = exp_q.pop_front();
      got = {ir_out, tr_out, two_byte, instr_addr, pc_out};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL one_byte_instr: got %h expected %h", got, e);
      end
    end
  endtask

  task automatic test_stall();
    exp_t held;
    held = '{ir: 8'hA3, tr: 8'h00, two: 1'b0, addr: 13'h0000, pc: 13'h0001};
    mem[1] = 8'h80;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      got = {ir_out, tr_out, two_byte, instr_addr, pc_out};
      checks++;
      if (got !== held || instr_valid !== 1'b1 || mem_req !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: got %h valid=%b req=%b expected %h/1/0", got, instr_valid, mem_req, held);
      end
    end
    instr_ready = 1'b1;
    exp_q.push_back('{ir: 8'h80, tr: 8'h00, two: 1'b0, addr: 13'h0001, pc: 13'h0002});
    @(negedge clk);
    instr_ready = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 13'h0001) begin
      errors++;
      $display("FAIL stall_next_fetch: req=%b addr=%h expected 1/0001", mem_req, mem_addr);
    end
    wait_valid(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stall_timeout: instr_valid=0 expected 1");
    end else begin
      e = exp_q.pop_front();
      got = {ir_out, tr_out, two_byte, instr_addr, pc_out};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL stall_instr: got %h expected %h", got, e);
      end
    end
  endtask

  task automatic test_two_byte_wait();
    mem[4] = 8'h25;
    mem[5] = 8'h7F;
    wait_cyc = 2;
    fetch_log.delete();
    pc_load = 1'b1;
    pc_target = 13'h0004;
    instr_ready = 1'b1;
    exp_q.push_back('{ir: 8'h25, tr: 8'h7F, two: 1'b1, addr: 13'h0004, pc: 13'h0006});
    @(negedge clk);
    pc_load = 1'b0;
    instr_ready = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 13'h0004) begin
      errors++;
      $display("FAIL redirect_valid: valid=%b req=%b addr=%h expected 0/1/0004", instr_valid, mem_req, mem_addr);
    end
    wait_valid(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL two_byte_timeout: instr_valid=0 expected 1");
    end else begin
      e = exp_q.pop_front();
      got = {ir_out, tr_out, two_byte, instr_addr, pc_out};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL two_byte_instr: got %h expected %h", got, e);
      end
    end
    checks++;
    if (fetch_log.size() != 2 || fetch_log[0] !== 13'h0004 || fetch_log[1] !== 13'h0005) begin
      errors++;
      $display("FAIL two_byte_addrs: %0d fetches expected 2 (0004,0005)", fetch_log.size());
    end
  endtask

  task automatic test_redirect_in_flight();
    bit found;
    mem[6] = 8'h10;
    mem[7] = 8'h55;
    mem[13'h1ABC] = 8'h81;
    wait_cyc = 4;
    fetch_log.delete();
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_req === 1'b1 && mem_addr === 13'h0007) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL fetch2_reach: operand fetch from 0007 not seen, expected it");
    end
    pc_load = 1'b1;
    pc_target = 13'h0123;
    @(negedge clk);
    pc_target = 13'h1ABC;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 13'h0007 || pc_out !== 13'h0007) begin
      errors++;
      $display("FAIL pending_hold: req=%b addr=%h pc=%h expected 1/0007/0007", mem_req, mem_addr, pc_out);
    end
    exp_q.push_back('{ir: 8'h81, tr: 8'h7F, two: 1'b0, addr: 13'h1ABC, pc: 13'h1ABD});
    @(negedge clk);
    pc_load = 1'b0;
    wait_valid(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL redirect_timeout: instr_valid=0 expected 1");
    end else begin
      e = exp_q.pop_front();
      got = {ir_out, tr_out, two_byte, instr_addr, pc_out};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL redirect_instr: got %h expected %h", got, e);
      end
    end
    checks++;
    if (fetch_log.size() != 3 || fetch_log[1] !== 13'h0007 || fetch_log[2] !== 13'h1ABC) begin
      errors++;
      $display("FAIL redirect_addrs: %0d fetches expected 3 (0006,0007,1ABC)", fetch_log.size());
    end
  endtask

  task automatic test_wrap();
    mem[13'h1FFF] = 8'hC1;
    wait_cyc = 0;
    fetch_log.delete();
    pc_load = 1'b1;
    pc_target = 13'h1FFF;
    exp_q.push_back('{ir: 8'hC1, tr: 8'hA3, two: 1'b1, addr: 13'h1FFF, pc: 13'h0001});
    @(negedge clk);
    pc_load = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || mem_addr !== 13'h1FFF) begin
      errors++;
      $display("FAIL drop_on_load: valid=%b addr=%h expected 0/1FFF", instr_valid, mem_addr);
    end
    wait_valid(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wrap_timeout: instr_valid=0 expected 1");
    end else begin
      e = exp_q.pop_front();
      got = {ir_out, tr_out, two_byte, instr_addr, pc_out};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL wrap_instr: got %h expected %h", got, e);
      end
    end
    checks++;
    if (fetch_log.size() != 2 || fetch_log[1] !== 13'h0000) begin
      errors++;
      $display("FAIL wrap_addrs: %0d fetches expected 2 (1FFF,0000)", fetch_log.size());
    end
  endtask

  task automatic test_en_low();
    en = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b0 || instr_valid !== 1'b0 || pc_out !== 13'h0001) begin
        errors++;
        $display("FAIL idle_hold: req=%b valid=%b pc=%h expected 0/0/0001", mem_req, instr_valid, pc_out);
      end
    end
    wait_cyc = 3;
    en = 1'b1;
    exp_q.push_back('{ir: 8'h80, tr: 8'hA3, two: 1'b0, addr: 13'h0001, pc: 13'h0002});
    @(negedge clk);
    en = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 13'h0001) begin
      errors++;
      $display("FAIL en_low_fetch: req=%b addr=%h expected 1/0001", mem_req, mem_addr);
    end
    wait_valid(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL en_low_timeout: instr_valid=0 expected 1");
    end else begin
      e = exp_q.pop_front();
      got = {ir_out, tr_out, two_byte, instr_addr, pc_out};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL en_low_instr: got %h expected %h", got, e);
      end
    end
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL en_low_idle: req=%b valid=%b expected 0/0", mem_req, instr_valid);
    end
  endtask

  task automatic test_reset_midfetch();
    auto_mem = 1'b0;
    mem_ack = 1'b0;
    en = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 13'h0002) begin
      errors++;
      $display("FAIL rst_pre_fetch: req=%b addr=%h expected 1/0002", mem_req, mem_addr);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || instr_valid !== 1'b0 || pc_out !== 13'h0000 || ir_out !== 8'h00) begin
      errors++;
      $display("FAIL rst_async: req=%b valid=%b pc=%h ir=%h expected 0/0/0000/00", mem_req, instr_valid, pc_out, ir_out);
    end
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 8'h99;
    @(negedge clk);
    mem_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (mem_req !== 1'b0 || instr_valid !== 1'b0 || pc_out !== 13'h0000 || ir_out !== 8'h00) begin
        errors++;
        $display("FAIL late_ack: req=%b valid=%b pc=%h ir=%h expected 0/0/0000/00", mem_req, instr_valid, pc_out, ir_out);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
    test_reset();
    test_one_byte();
    test_stall();
    test_two_byte_wait();
    test_redirect_in_flight();
    test_wrap();
    test_en_low();
    test_reset_midfetch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
